ham_encoder_tx: RTL and testbench

Hamming(7,4) encoder and serial transmitter. It is the transmit-side counterpart of ham_decoder. It accepts 4-bit data words on a valid/ready handshake and encodes each into a 7-bit single-error-correcting codeword. The codeword is shifted out one bit per cycle under backpressure. Optional single-bit error injection per word lets benches exercise the decoder's correction path.

---
 rtl/ham_encoder_tx.sv | 137 +++++++++++++
 tb/tb_ham_encoder_tx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ham_encoder_tx.sv
// Hamming(7,4) encoder with optional per-word single-bit error injection,
// followed by a backpressured serializer that emits one codeword bit per cycle.
module ham_encoder_tx #(
    parameter int LSB_FIRST  = 1,
    parameter int ODD_PARITY = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       inj_pos,
    output logic [6:0]       enc_ham_data,
    output logic             tx_bit,
    output logic             tx_valid,
    output logic             tx_last,
    input  logic             tx_ready,
    output logic [CNT_W-1:0] word_cnt
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;
    localparam logic [2:0] LAST_IDX = 3'd6;
    localparam logic       PAR_INV  = (ODD_PARITY != 0);
    localparam logic       LSB_SEL  = (LSB_FIRST != 0);

    function automatic logic parity3(input logic a, input logic b, input logic c);
        return a ^ b ^ c ^ PAR_INV;
    endfunction

    // Codeword bit p-1 holds Hamming position p.
    function automatic logic [6:0] ham_encode(input logic [3:0] d);
        logic [6:0] cw;
        cw[0] = parity3(d[0], d[1], d[3]);
        cw[1] = parity3(d[0], d[2], d[3]);
        cw[2] = d[0];
        cw[3] = parity3(d[1], d[2], d[3]);
        cw[4] = d[1];
        cw[5] = d[2];
        cw[6] = d[3];
        return cw;
    endfunction

    function automatic logic [6:0] inject_mask(input logic [2:0] pos);
        logic [6:0] m;
        case (pos)
            3'd1:    m = 7'b0000001;
            3'd2:    m = 7'b0000010;
            3'd3:    m = 7'b0000100;
            3'd4:    m = 7'b0001000;
            3'd5:    m = 7'b0010000;
            3'd6:    m = 7'b0100000;
            3'd7:    m = 7'b1000000;
            default: m = 7'b0000000;
        endcase
        return m;
    endfunction

    logic [0:0]       r_state;
    logic [2:0]       r_cnt;
    logic [6:0]       r_shift;
    logic [6:0]       r_enc;
    logic [CNT_W-1:0] r_word_cnt;

    logic [0:0]       w_state_nxt;
    logic [2:0]       w_cnt_nxt;
    logic [6:0]       w_shift_nxt;
    logic [6:0]       w_enc_nxt;
    logic [CNT_W-1:0] w_word_cnt_nxt;

    logic             w_accept;
    logic             w_xfer;
    logic             w_done;
    logic [6:0]       w_code;
    logic [6:0]       w_shift_step;

    assign w_xfer       = (r_state == ST_SHIFT) && tx_ready;
    assign w_done       = w_xfer && (r_cnt == LAST_IDX);
    assign in_ready     = (r_state == ST_IDLE) || w_done;
    assign w_accept     = in_valid && in_ready;
    assign w_code       = ham_encode(in_data) ^ inject_mask(inj_pos);
    assign w_shift_step = LSB_SEL ? {1'b0, r_shift[6:1]} : {r_shift[5:0], 1'b0};

    // Next-state decode: a new accept on the last transfer reloads with no idle bubble.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_shift_nxt    = r_shift;
        w_enc_nxt      = r_enc;
        w_word_cnt_nxt = r_word_cnt;
        if (w_accept) begin
            w_state_nxt = ST_SHIFT;
            w_cnt_nxt   = 3'd0;
            w_shift_nxt = w_code;
            w_enc_nxt   = w_code;
        end else if (w_done) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 3'd0;
            w_shift_nxt = 7'd0;
        end else if (w_xfer) begin
            w_cnt_nxt   = r_cnt + 3'd1;
            w_shift_nxt = w_shift_step;
        end else begin
            w_state_nxt = r_state;
        end
        if (w_done) begin
            w_word_cnt_nxt = r_word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            w_word_cnt_nxt = r_word_cnt;
        end
    end

    // State registers; reset discards any partially sent codeword.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 3'd0;
            r_shift    <= 7'd0;
            r_enc      <= 7'd0;
            r_word_cnt <= {CNT_W{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_enc      <= w_enc_nxt;
            r_word_cnt <= w_word_cnt_nxt;
        end
    end

    assign enc_ham_data = r_enc;
    assign tx_valid     = (r_state == ST_SHIFT);
    assign tx_bit       = LSB_SEL ? r_shift[0] : r_shift[6];
    assign tx_last      = (r_state == ST_SHIFT) && (r_cnt == LAST_IDX);
    assign word_cnt     = r_word_cnt;

endmodule

// File: tb/tb_ham_encoder_tx.sv
// Scoreboard bench for ham_encoder_tx: dut0 is the default LSB-first even-parity
// build, dut1 is MSB-first odd-parity with a 4-bit word counter.
module tb_ham_encoder_tx;

    typedef struct {
        logic [3:0] data;
        logic [2:0] inj;
        logic [6:0] code;
        logic       has_code;
    } sb_t;

    logic        clk;
    logic        rst;
    logic [3:0]  in_data0, in_data1;
    logic        in_valid0, in_valid1;
    logic        in_ready0, in_ready1;
    logic [2:0]  inj0, inj1;
    logic [6:0]  enc0, enc1;
    logic        tx_bit0, tx_bit1, tx_valid0, tx_valid1, tx_last0, tx_last1;
    logic        tx_ready0, tx_ready1;
    logic [15:0] wc0;
    logic [3:0]  wc1;

    int n_chk  = 0;
    int n_fail = 0;

    sb_t        q0[$];
    logic [1:0] q1[$];
    int         idx0 = 0;
    logic [6:0] rx0;
    int         run_len = 0;
    int         last_run = 0;
    logic       prev_stall = 1'b0;
    logic       prev_bit, prev_last;
    logic       bp_en = 1'b0;

    ham_encoder_tx #(.LSB_FIRST(1), .ODD_PARITY(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
        .inj_pos(inj0), .enc_ham_data(enc0), .tx_bit(tx_bit0), .tx_valid(tx_valid0),
        .tx_last(tx_last0), .tx_ready(tx_ready0), .word_cnt(wc0));

    ham_encoder_tx #(.LSB_FIRST(0), .ODD_PARITY(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .inj_pos(inj1), .enc_ham_data(enc1), .tx_bit(tx_bit1), .tx_valid(tx_valid1),
        .tx_last(tx_last1), .tx_ready(tx_ready1), .word_cnt(wc1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // dut0 monitor: bit order, tx_last/in_ready timing, stall stability, decode of each word.
    initial begin
        sb_t        e;
        logic [6:0] cw;
        logic [2:0] syn;
        logic [6:0] fix;
        forever begin
            @(negedge clk);
            if (rst) begin
                q0.delete();
                idx0 = 0;
                prev_stall = 1'b0;
                run_len = 0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 32'(tx_valid0), 32'd1);
                    check("stall_bit", 32'(tx_bit0), 32'(prev_bit));
                    check("stall_last", 32'(tx_last0), 32'(prev_last));
                end
                prev_stall = tx_valid0 && !tx_ready0;
                prev_bit   = tx_bit0;
                prev_last  = tx_last0;
                if (tx_valid0) run_len++;
                else if (run_len > 0) begin
                    last_run = run_len;
                    run_len  = 0;
                end
                if (tx_valid0 && tx_ready0) begin
                    if (q0.size() == 0) begin
                        check("unexpected_bit", 32'd1, 32'd0);
                    end else begin
                        e = q0[0];
                        if (idx0 == 0 && e.has_code) check("enc_ham_data", 32'(enc0), 32'(e.code));
                        check("tx_last", 32'(tx_last0), 32'(idx0 == 6));
                        check("in_ready", 32'(in_ready0), 32'(idx0 == 6));
                        rx0[idx0] = tx_bit0;
                        idx0++;
                        if (idx0 == 7) begin
                            cw = rx0;
                            if (e.has_code) check("serial_code", 32'(cw), 32'(e.code));
                            syn = {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
                                   cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
                                   cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
                            check("syndrome", 32'(syn), 32'(e.inj));
                            fix = cw;
                            if (syn != 3'd0) fix[syn - 3'd1] = ~fix[syn - 3'd1];
                            check("corrected", 32'({fix[6], fix[5], fix[4], fix[2]}), 32'(e.data));
                            void'(q0.pop_front());
                            idx0 = 0;
                        end
                    end
                end
            end
        end
    end

    // dut1 monitor: MSB-first bit stream against hand-computed odd-parity codewords.
    initial begin
        logic [1:0] eb;
        forever begin
            @(negedge clk);
            if (rst) begin
                q1.delete();
            end else if (tx_valid1 && tx_ready1) begin
                if (q1.size() == 0) begin
                    check("unexpected_bit1", 32'd1, 32'd0);
                end else begin
                    eb = q1.pop_front();
                    check("tx_bit1", 32'(tx_bit1), 32'(eb[1]));
                    check("tx_last1", 32'(tx_last1), 32'(eb[0]));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) tx_ready0 = 1'($urandom_range(0, 1));
        end
    end

    task automatic send0(input logic [3:0] d, input logic [2:0] p, input logic [6:0] c, input logic hc);
        sb_t e;
        bit  ok = 1'b0;
        e.data = d; e.inj = p; e.code = c; e.has_code = hc;
        in_data0 = d; inj0 = p; in_valid0 = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready0) begin ok = 1'b1; break; end
        end
        if (ok) q0.push_back(e);
        else check("accept_timeout0", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
    endtask

    task automatic send1(input logic [3:0] d, input logic [6:0] c);
        bit ok = 1'b0;
        in_data1 = d; inj1 = 3'd0; in_valid1 = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready1) begin ok = 1'b1; break; end
        end
        if (ok) begin
            for (int b = 6; b >= 0; b--) q1.push_back({c[b], 1'(b == 0)});
        end else check("accept_timeout1", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!tx_valid0 && !tx_valid1 && q0.size() == 0 && q1.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_data0 = 4'd0; in_valid0 = 1'b0; inj0 = 3'd0; tx_ready0 = 1'b1;
        in_data1 = 4'd0; in_valid1 = 1'b0; inj1 = 3'd0; tx_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready0), 32'd1);
        check("rst_tx_valid", 32'(tx_valid0), 32'd0);
        check("rst_tx_bit", 32'(tx_bit0), 32'd0);
        check("rst_tx_last", 32'(tx_last0), 32'd0);
        check("rst_enc", 32'(enc0), 32'd0);
        check("rst_wc", 32'(wc0), 32'd0);
        @(posedge clk);
        #1;

        send0(4'b1011, 3'd0, 7'b1010101, 1'b1);
        wait_idle();
        check("t1_wc", 32'(wc0), 32'd1);
        check("t1_enc_hold", 32'(enc0), 32'(7'b1010101));

        send0(4'b0000, 3'd0, 7'b0000000, 1'b1);
        send0(4'b1111, 3'd0, 7'b1111111, 1'b1);
        send0(4'b0001, 3'd0, 7'b0000111, 1'b1);
        send0(4'b0110, 3'd0, 7'b0110011, 1'b1);
        send0(4'b1001, 3'd0, 7'b1001100, 1'b1);
        wait_idle();
        check("t2_wc", 32'(wc0), 32'd6);

        send0(4'b1011, 3'd7, 7'b0010101, 1'b1);
        send0(4'b0101, 3'd3, 7'b0101001, 1'b1);
        send0(4'b1100, 3'd1, 7'b1100000, 1'b1);
        wait_idle();
        check("t3_wc", 32'(wc0), 32'd9);

        for (int d = 0; d < 16; d++)
            for (int p = 0; p < 8; p++)
                send0(4'(d), 3'(p), 7'd0, 1'b0);
        wait_idle();
        check("sweep_wc", 32'(wc0), 32'd137);

        send0(4'b1011, 3'd0, 7'b1010101, 1'b1);
        send0(4'b0110, 3'd0, 7'b0110011, 1'b1);
        send0(4'b1001, 3'd0, 7'b1001100, 1'b1);
        wait_idle();
        check("t4_run_len", 32'(last_run), 32'd21);
        check("t4_wc", 32'(wc0), 32'd140);

        bp_en = 1'b1;
        send0(4'b1011, 3'd0, 7'b1010101, 1'b1);
        send0(4'b0110, 3'd0, 7'b0110011, 1'b1);
        send0(4'b0101, 3'd3, 7'b0101001, 1'b1);
        send0(4'b1100, 3'd1, 7'b1100000, 1'b1);
        wait_idle();
        bp_en = 1'b0;
        tx_ready0 = 1'b1;
        check("bp_wc", 32'(wc0), 32'd144);

        send0(4'b1001, 3'd0, 7'b1001100, 1'b1);
        for (int i = 0; i < 100 && idx0 != 3; i++) @(posedge clk);
        check("t5_reached_bit3", 32'(idx0), 32'd3);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_tx_valid", 32'(tx_valid0), 32'd0);
        check("t5_enc", 32'(enc0), 32'd0);
        check("t5_wc", 32'(wc0), 32'd0);
        check("t5_in_ready", 32'(in_ready0), 32'd1);
        @(posedge clk);
        #1;
        send0(4'b0001, 3'd0, 7'b0000111, 1'b1);
        wait_idle();
        check("t5_wc_after", 32'(wc0), 32'd1);

        for (int i = 0; i < 15; i++) begin
            if (i % 2 == 0) send1(4'b0000, 7'b0001011);
            else            send1(4'b1011, 7'b1011110);
        end
        wait_idle();
        check("t6_wc15", 32'(wc1), 32'd15);
        send1(4'b1011, 7'b1011110);
        wait_idle();
        check("t6_wrap", 32'(wc1), 32'd0);
        check("t6_enc_odd", 32'(enc1), 32'(7'b1011110));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
